// File: rtl/ovl_fabric_pkg.sv
// rtl/ovl_fabric_pkg.sv - shared defaults and types for the assertion-fabric checker slots
package ovl_fabric_pkg;

  localparam int NUM_CKS_WIDTH_DEF = 3;
  localparam int NUM_CKS_MAX_DEF   = (1 << NUM_CKS_WIDTH_DEF) - 1;

  typedef logic [NUM_CKS_WIDTH_DEF-1:0] num_cks_t;

endpackage

// File: rtl/ovl_next_core.sv
// rtl/ovl_next_core.sv - start-event monitor shift register and registered violation flag
module ovl_next_core
  import ovl_fabric_pkg::*;
#(
  parameter int NUM_CKS_WIDTH = NUM_CKS_WIDTH_DEF,
  parameter int NUM_CKS_MAX   = NUM_CKS_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_CKS_WIDTH-1:0] num_cks,
  input  logic                     start_event,
  input  logic                     test_expr,
  output logic                     fire
);

  logic [NUM_CKS_MAX-1:0]   mon;
  logic [NUM_CKS_MAX:0]     mon_ext;
  logic [NUM_CKS_WIDTH-1:0] idx;

  // num_cks == 0 wraps idx to NUM_CKS_MAX, which lands on the zero pad bit
  assign mon_ext = {1'b0, mon};
  assign idx     = num_cks - NUM_CKS_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      mon  <= '0;
      fire <= 1'b0;
    end else begin
      mon  <= {mon[NUM_CKS_MAX-2:0], start_event};
      fire <= mon_ext[idx] & ~test_expr & (num_cks != '0);
    end
  end

endmodule

// File: rtl/ovl_next_wrapper.sv
// rtl/ovl_next_wrapper.sv - "next" checker slot; OVL_NEXT_ENABLE_GATE_EN adds enable gating
module ovl_next_wrapper
  import ovl_fabric_pkg::*;
#(
  parameter int NUM_CKS_WIDTH = NUM_CKS_WIDTH_DEF,
  parameter int NUM_CKS_MAX   = NUM_CKS_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CKS_WIDTH-1:0] num_cks,
  input  logic                     start_event,
  input  logic                     test_expr,
  input  logic                     prevConfigInvalid,
  output logic                     out
);

  logic clear;
  logic gate;
  logic fire;

`ifdef OVL_NEXT_ENABLE_GATE_EN
  assign clear = rst | ~enable;
  assign gate  = enable;
`else
  logic unused_enable;
  assign unused_enable = enable;
  assign clear = rst;
  assign gate  = 1'b1;
`endif

  ovl_next_core #(
    .NUM_CKS_WIDTH (NUM_CKS_WIDTH),
    .NUM_CKS_MAX   (NUM_CKS_MAX)
  ) u_core (
    .clk         (clk),
    .clr         (clear),
    .num_cks     (num_cks),
    .start_event (start_event),
    .test_expr   (test_expr),
    .fire        (fire)
  );

  // Mask is combinational so out never overlaps prevConfigInvalid
  assign out = fire & ~prevConfigInvalid & gate;

endmodule

// File: tb/tb_ovl_next_wrapper.sv
// tb/tb_ovl_next_wrapper.sv - scoreboard bench for ovl_next_wrapper
module tb_ovl_next_wrapper;
  import ovl_fabric_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     enable = 1'b1;
  num_cks_t num_cks = '0;
  logic     start_event = 1'b0;
  logic     test_expr = 1'b0;
  logic     prevConfigInvalid = 1'b0;
  logic     out;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  logic sb[$];
  logic hist[0:7];

  always #5 clk = ~clk;

  ovl_next_wrapper dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .num_cks           (num_cks),
    .start_event       (start_event),
    .test_expr         (test_expr),
    .prevConfigInvalid (prevConfigInvalid),
    .out               (out)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the prediction made last
  // cycle, then predict next cycle's fire from the start-event history.
  task automatic step(input logic r, input logic se, input logic te,
                      input num_cks_t n, input logic pci);
    logic f;
    logic nf;
    @(posedge clk);
    #1;
    rst = r;
    start_event = se;
    test_expr = te;
    num_cks = n;
    prevConfigInvalid = pci;
    #1;
    if (sb.size() != 0) begin
      f = sb.pop_front();
      check("out_sb", out, f & ~pci);
    end
    if (out === 1'b1) pulses++;
    nf = !r && (n != 0) && hist[n] && !te;
    sb.push_back(nf);
    if (r) begin
      for (int k = 0; k < 8; k++) hist[k] = 1'b0;
    end else begin
      for (int k = 7; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = se;
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) hist[k] = 1'b0;

    // basic violation: start t2, N=3, test_expr low at t5 -> out at t6
    pulses = 0;
    step(1, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    check("reset_out", out, 1'b0);
    step(0, 1, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 1, 3, 0);
    check("basic_t6", out, 1'b1);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    check("basic_count", pulses == 1, 1'b1);

    // test_expr high at t5 -> no pulse
    pulses = 0;
    step(1, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    check("pass_count", pulses == 0, 1'b1);

    // prevConfigInvalid at t6 masks the pulse
    pulses = 0;
    step(1, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 1, 3, 1);
    check("mask_t6", out, 1'b0);
    step(0, 0, 1, 3, 0);
    check("mask_count", pulses == 0, 1'b1);

    // latency sweep over every N
    for (int n = 1; n <= 7; n++) begin
      pulses = 0;
      step(1, 0, 1, num_cks_t'(n), 0);
      step(0, 1, 0, num_cks_t'(n), 0);
      for (int j = 1; j <= n + 2; j++) begin
        step(0, 0, 0, num_cks_t'(n), 0);
        check($sformatf("sweep_n%0d_j%0d", n, j), out, j == n + 1);
      end
      check($sformatf("sweep_n%0d_count", n), pulses == 1, 1'b1);
    end

    // reset mid-window discards the pending start
    pulses = 0;
    step(1, 0, 1, 3, 0);
    step(0, 0, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(1, 0, 0, 3, 0);
    for (int j = 0; j < 6; j++) step(0, 0, 0, 3, 0);
    check("rst_mid_count", pulses == 0, 1'b1);

    // num_cks == 0 never fires
    pulses = 0;
    step(1, 0, 0, 0, 0);
    for (int j = 0; j < 40; j++) step(0, 1'($urandom_range(0, 1)), 0, 0, 0);
    check("zero_n_count", pulses == 0, 1'b1);

    // back-to-back starts -> back-to-back pulses
    pulses = 0;
    step(1, 0, 1, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    check("b2b_first", out, 1'b1);
    step(0, 0, 1, 2, 0);
    check("b2b_second", out, 1'b1);
    step(0, 0, 1, 2, 0);
    check("b2b_count", pulses == 2, 1'b1);

    // num_cks changed mid-window: value at check time is used
    pulses = 0;
    step(1, 0, 1, 5, 0);
    step(0, 1, 1, 5, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 1, 5, 0);
    check("midchange_pulse", out, 1'b1);
    for (int j = 0; j < 5; j++) step(0, 0, 1, 5, 0);
    check("midchange_count", pulses == 1, 1'b1);

    // random traffic checked by the scoreboard only
    step(1, 0, 0, 3, 0);
    for (int j = 0; j < 300; j++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), num_cks_t'($urandom_range(0, 7)),
           ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
